// File: rtl/led_status_pkg.sv
// Shared types and constants for the LED status arbiter.
// Pattern codes, FSM states, frame length and blink windows.
package led_status_pkg;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'b00,
    PAT_SLOW  = 2'b01,
    PAT_FAST  = 2'b10,
    PAT_BEAT  = 2'b11
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int unsigned FRAME_LEN = 1000;

  localparam logic [9:0] FRAME_LAST  = 10'(FRAME_LEN - 1);
  localparam logic [9:0] SLOW_ON     = 10'd500;
  localparam logic [9:0] FAST_PERIOD = 10'd250;
  localparam logic [9:0] FAST_ON     = 10'd125;
  localparam logic [9:0] BEAT_W      = 10'd50;
  localparam logic [9:0] BEAT_0      = 10'd250;
  localparam logic [9:0] BEAT_1      = 10'd500;
  localparam logic [9:0] BEAT_2      = 10'd750;

  function automatic logic in_win(
    input logic [9:0] ph,
    input logic [9:0] start
  );
    return (ph >= start) && (ph < start + BEAT_W);
  endfunction

  function automatic logic pattern_on_f(
    input pattern_e   pat,
    input logic [9:0] ph
  );
    logic on;
    on = 1'b0;
    case (pat)
      PAT_SOLID: on = 1'b1;
      PAT_SLOW:  on = ph < SLOW_ON;
      PAT_FAST:  on = (ph % FAST_PERIOD) < FAST_ON;
      PAT_BEAT:  on = in_win(ph, BEAT_0)
                   || in_win(ph, BEAT_1)
                   || in_win(ph, BEAT_2);
      default:   on = 1'b0;
    endcase
    return on;
  endfunction

endpackage

// File: rtl/led_status_arbiter_pattern_gen.sv
// Tick prescaler, frame phase counter and blink pattern decode.
// Phase restarts on phase_clr so every new grant begins its frame at 0.
module led_pattern_gen
  import led_status_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 125000000,
  parameter int unsigned TICK_HZ = 1000
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     phase_clr,
  input  pattern_e pattern,
  output logic     tick,
  output logic     pattern_on
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre;
  logic [9:0]    phase;

  assign tick = (pre == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else begin
      pre <= tick ? '0 : pre + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (phase_clr) begin
      phase <= '0;
    end else if (tick) begin
      phase <= (phase == FRAME_LAST) ? '0 : phase + 10'd1;
    end
  end

  assign pattern_on = pattern_on_f(pattern, phase);

endmodule

// File: rtl/led_status_arbiter.sv
// Fixed-priority LED bank arbiter with minimum hold and blink patterns.
// Optional LED_LAMP_TEST_EN adds a lamp_test port forcing all LEDs on.
module led_status_arbiter
  import led_status_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned N_LED    = 8,
  parameter int unsigned CLK_HZ   = 125000000,
  parameter int unsigned TICK_HZ  = 1000,
  parameter int unsigned MIN_HOLD = 200
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [2*N_REQ-1:0]     req_pattern,
  input  logic [N_LED*N_REQ-1:0] req_mask,
`ifdef LED_LAMP_TEST_EN
  input  logic                   lamp_test,
`endif
  output logic [N_LED-1:0]       led,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned HW = $clog2(MIN_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);

  state_e           state;
  state_e           state_nx;
  logic [IW-1:0]    owner;
  pattern_e         pat;
  logic [N_LED-1:0] mask;
  logic [HW-1:0]    hold;
  logic [N_LED-1:0] led_d;

  logic             any;
  logic [IW-1:0]    winner;
  logic [N_REQ-1:0] win_oh;
  pattern_e         win_pat;
  logic [N_LED-1:0] win_mask;
  logic             regrant;
  logic             expired;
  logic             higher;
  logic             owner_req;
  logic             tick;
  logic             pattern_on;

  // Lowest index wins: scan downward so the last hit is the winner.
  always_comb begin
    any      = 1'b0;
    winner   = '0;
    win_oh   = '0;
    win_pat  = PAT_SOLID;
    win_mask = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any       = 1'b1;
        winner    = IW'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_pat   = pattern_e'(req_pattern[2*i +: 2]);
        win_mask  = req_mask[N_LED*i +: N_LED];
      end
    end
  end

  assign expired   = (hold == HOLD_MAX);
  assign higher    = any && (winner < owner);
  assign owner_req = req_valid[owner];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    regrant  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any) begin
          state_nx = ST_GRANT;
          regrant  = 1'b1;
        end
      end
      ST_GRANT, ST_HOLD: begin
        if (!expired) begin
          state_nx = owner_req ? ST_GRANT : ST_HOLD;
        end else if (higher) begin
          state_nx = ST_GRANT;
          regrant  = 1'b1;
        end else if (owner_req) begin
          state_nx = ST_GRANT;
        end else if (any) begin
          state_nx = ST_GRANT;
          regrant  = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= '0;
      grant <= '0;
      pat   <= PAT_SOLID;
      mask  <= '0;
      hold  <= '0;
    end else if (regrant) begin
      owner <= winner;
      grant <= win_oh;
      pat   <= win_pat;
      mask  <= win_mask;
      hold  <= '0;
    end else if (state_nx == ST_IDLE) begin
      grant <= '0;
      hold  <= '0;
    end else if (tick && state != ST_IDLE && !expired) begin
      hold <= hold + HW'(1);
    end
  end

  led_pattern_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_pat (
    .clk        (clk),
    .rst_n      (rst_n),
    .phase_clr  (regrant),
    .pattern    (pat),
    .tick       (tick),
    .pattern_on (pattern_on)
  );

  always_comb begin
    led_d = '0;
    if (state != ST_IDLE && pattern_on) begin
      led_d = mask;
    end
`ifdef LED_LAMP_TEST_EN
    if (lamp_test) begin
      led_d = '1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      led <= led_d;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
